// File: rtl/neuron_pkg.sv
// Shared neuron-datapath definitions: accumulator FSM states,
// FP32 constants and default sizing.
package neuron_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [31:0] ZERO = 32'h0000_0000;

    localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/Addition_Subtraction.sv
// Combinational FP32 adder/subtractor (op 0 = add, 1 = subtract),
// round-to-nearest-even, Exception on Inf/NaN input or overflow.
module Addition_Subtraction (
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    input  logic        AddBar_Sub,
    output logic        Exception,
    output logic [31:0] result
);

    logic        sa, sb, s_big, s_small, special, found, rnd;
    logic [7:0]  ea, eb, e_big, e_small, diff, ebits;
    logic [23:0] ma, mb, m_big, m_small;
    logic [26:0] aligned, norm;
    logic [27:0] sum;
    logic [4:0]  lz, dshift;
    logic [8:0]  exp_n;
    logic [30:0] mag;

    always_comb begin
        sa = a_operand[31];
        sb = b_operand[31] ^ AddBar_Sub;
        ea = (a_operand[30:23] == 8'd0) ? 8'd1 : a_operand[30:23];
        eb = (b_operand[30:23] == 8'd0) ? 8'd1 : b_operand[30:23];
        ma = {(a_operand[30:23] != 8'd0), a_operand[22:0]};
        mb = {(b_operand[30:23] != 8'd0), b_operand[22:0]};
        special = (&a_operand[30:23]) | (&b_operand[30:23]);

        if ({ea, ma} >= {eb, mb}) begin
            s_big = sa; e_big = ea; m_big = ma;
            s_small = sb; e_small = eb; m_small = mb;
        end else begin
            s_big = sb; e_big = eb; m_big = mb;
            s_small = sa; e_small = ea; m_small = ma;
        end

        diff    = e_big - e_small;
        aligned = (diff > 8'd26) ? 27'd0 : ({m_small, 3'b000} >> diff);
        if (s_big ^ s_small)
            sum = {1'b0, m_big, 3'b000} - {1'b0, aligned};
        else
            sum = {1'b0, m_big, 3'b000} + {1'b0, aligned};

        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (sum[i]) found = 1'b1;
                else        lz = lz + 5'd1;
            end
        end

        // Left shift is capped so tiny results land as denormals
        dshift = 5'd0;
        if (sum[27]) begin
            norm  = sum[27:1];
            exp_n = {1'b0, e_big} + 9'd1;
        end else if ({3'b000, lz} < e_big) begin
            norm  = sum[26:0] << lz;
            exp_n = {1'b0, e_big} - {4'b0000, lz};
        end else begin
            dshift = 5'(e_big - 8'd1);
            norm   = sum[26:0] << dshift;
            exp_n  = 9'd0;
        end

        ebits = norm[26] ? exp_n[7:0] : 8'd0;
        rnd   = norm[2] & (norm[3] | norm[1] | norm[0]);
        mag   = {ebits, norm[25:3]} + {30'd0, rnd};

        Exception = special | exp_n[8] | (&exp_n[7:0]) | (&mag[30:23]);
        if (Exception)
            result = {s_big, 8'hFF, 23'd0};
        else if (sum == 28'd0)
            result = 32'd0;
        else
            result = {s_big, mag};
    end

endmodule

// File: rtl/weight_accumulator.sv
// Per-timestep FP32 synaptic weight accumulator: spikes queue in a
// small FIFO and are summed one per cycle into a running total.
module weight_accumulator
    import neuron_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int CNT_W      = 8
) (
    input  logic             CLK_Accumulator,
    input  logic             RST_n,
    input  logic             clear,
    input  logic             spike_valid,
    input  logic [31:0]      spike_weight,
    output logic             spike_ready,
    input  logic             timestep_end,
    output logic [31:0]      input_weight,
    output logic             weight_valid,
    input  logic             weight_ack,
    output logic [CNT_W-1:0] event_count,
    output logic             acc_exception
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [1:0]       state_q, state_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      in_w_q, in_w_d;
    logic [31:0]      fifo_q [FIFO_DEPTH];
    logic [31:0]      fifo_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0] ev_q, ev_d;
    logic             exc_q, exc_d;
    logic             full, empty, push, pop, add_exc;
    logic [31:0]      head, sum;

    assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rd_q];

    assign spike_ready = (state_q == S_ACCUM) && !full;
    assign push        = spike_valid && spike_ready;
    assign pop         = ((state_q == S_ACCUM) || (state_q == S_DRAIN)) && !empty;

    assign input_weight  = in_w_q;
    assign weight_valid  = (state_q == S_DONE);
    assign event_count   = ev_q;
    assign acc_exception = exc_q;

    Addition_Subtraction u_add (
        .a_operand (acc_q),
        .b_operand (head),
        .AddBar_Sub(1'b0),
        .Exception (add_exc),
        .result    (sum)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        in_w_d  = in_w_q;
        fifo_d  = fifo_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        ev_d    = ev_q;
        exc_d   = exc_q;

        if (push) begin
            fifo_d[wr_q] = spike_weight;
            wr_d = wr_q + 1'b1;
            if (ev_q != '1) ev_d = ev_q + 1'b1;
        end
        if (pop) begin
            rd_d  = rd_q + 1'b1;
            acc_d = sum;
            if (add_exc) exc_d = 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: ;
        endcase

        unique case (state_q)
            S_ACCUM: if (timestep_end) state_d = S_DRAIN;
            S_DRAIN: begin
                // Pops update acc on the same edge, so empty means acc is final
                if (empty) begin
                    in_w_d  = acc_q;
                    state_d = S_DONE;
                end
            end
            S_DONE:  if (weight_ack) state_d = S_IDLE;
            default: ;
        endcase

        if (clear) begin
            state_d = S_ACCUM;
            acc_d   = ZERO;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            ev_d    = '0;
            exc_d   = 1'b0;
        end
    end

    always_ff @(posedge CLK_Accumulator or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            acc_q   <= ZERO;
            in_w_q  <= ZERO;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ev_q    <= '0;
            exc_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= ZERO;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            in_w_q  <= in_w_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            ev_q    <= ev_d;
            exc_q   <= exc_d;
            fifo_q  <= fifo_d;
        end
    end

endmodule
